alu_operand_stage: RTL and testbench

// - Registered operand stage directly upstream of the ALU32 datapath units (and/or/xor/add/slt).
// - Captures operand A, operand B and ALU op from decode/forwarding with a valid/ready handshake.
// - Presents the captured operands and op to the ALU on registered outputs.
// - 2-entry skid buffer: in_ready is a pure register output, full throughput, no comb ready path.

---
 rtl/alu_operand_stage.sv | 193 +++++++++++++++++++
 tb/tb_alu_operand_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Registered operand stage in front of the ALU32 datapath units.
// Captures {A, B, op} through a valid/ready handshake into a 2-entry skid
// buffer (MAIN drives the ALU, SKID holds one overflow entry). in_ready and
// out_valid are plain flop outputs, so no combinational path links the
// upstream and downstream handshakes, yet one transfer per clock is
// sustained while out_ready stays high.
//
// Optional feature macro: ALU_OPSTAGE_PERF_EN
//   defined   -> extra output xfer_count[31:0], number of Send handshakes
//                since reset (wraps, not cleared by flush)
//   undefined -> no xfer_count port and no counter logic
// ---------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int N   = 32,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,

    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    input  logic [OPW-1:0] in_op,

    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_a,
    output logic [N-1:0]   out_b,
    output logic [OPW-1:0] out_op
`ifdef ALU_OPSTAGE_PERF_EN
    ,
    output logic [31:0]    xfer_count
`endif
);

    // Occupancy of the buffer: nothing held, MAIN only, MAIN and SKID.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e         state_q,     state_d;
    logic           in_ready_q,  in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic [N-1:0]   main_a_q,  main_a_d;
    logic [N-1:0]   main_b_q,  main_b_d;
    logic [OPW-1:0] main_op_q, main_op_d;

    logic [N-1:0]   skid_a_q,  skid_a_d;
    logic [N-1:0]   skid_b_q,  skid_b_d;
    logic [OPW-1:0] skid_op_q, skid_op_d;

    logic           accept;
    logic           send;

    // Handshakes use only the registered flags, never a combinational ready.
    assign accept = in_valid  & in_ready_q;
    assign send   = out_valid_q & out_ready;

    // Next-state and data-load decisions for the skid buffer.
    always_comb begin
        // NOTE: every signal gets a hold/default value first, so no path through
        // the case below can leave one unassigned and infer a latch.
        state_d     = state_q;
        main_a_d    = main_a_q;
        main_b_d    = main_b_q;
        main_op_d   = main_op_q;
        skid_a_d    = skid_a_q;
        skid_b_d    = skid_b_q;
        skid_op_d   = skid_op_q;

        if (flush) begin
            // Drop everything held and any concurrent Accept; a concurrent Send
            // has already been sampled downstream, so nothing to undo there.
            // Data registers deliberately keep their stale contents.
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_a_d  = in_a;
                        main_b_d  = in_b;
                        main_op_d = in_op;
                        state_d   = ONE;
                    end
                end

                ONE: begin
                    if (accept && send) begin
                        // MAIN drains and refills on the same edge.
                        main_a_d  = in_a;
                        main_b_d  = in_b;
                        main_op_d = in_op;
                    end else if (accept) begin
                        // Downstream stalled: park the new entry behind MAIN.
                        skid_a_d  = in_a;
                        skid_b_d  = in_b;
                        skid_op_d = in_op;
                        state_d   = TWO;
                    end else if (send) begin
                        state_d   = EMPTY;
                    end
                end

                TWO: begin
                    // in_ready is low here, so no Accept can occur.
                    if (send) begin
                        main_a_d  = skid_a_q;
                        main_b_d  = skid_b_q;
                        main_op_d = skid_op_q;
                        state_d   = ONE;
                    end
                end

                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Handshake flags are a pure function of the next occupancy, so they
        // can be registered alongside the state.
        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
    end

    // State, handshake flags and both data entries.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: data registers are reset too, so out_* read as zero straight
        // out of reset instead of exposing power-up garbage to the ALU.
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_a_q    <= '0;
            main_b_q    <= '0;
            main_op_q   <= '0;
            skid_a_q    <= '0;
            skid_b_q    <= '0;
            skid_op_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            main_a_q    <= main_a_d;
            main_b_q    <= main_b_d;
            main_op_q   <= main_op_d;
            skid_a_q    <= skid_a_d;
            skid_b_q    <= skid_b_d;
            skid_op_q   <= skid_op_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_a     = main_a_q;
    assign out_b     = main_b_q;
    assign out_op    = main_op_q;

`ifdef ALU_OPSTAGE_PERF_EN
    logic [31:0] xfer_count_q, xfer_count_d;

    // Next transfer count: +1 per Send, natural wrap at 32 bits.
    always_comb begin
        xfer_count_d = xfer_count_q;
        if (send) begin
            xfer_count_d = xfer_count_q + 32'd1;
        end
    end

    // Transfer counter; only reset clears it, flush leaves it alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_count_q <= 32'd0;
        end else begin
            xfer_count_q <= xfer_count_d;
        end
    end

    assign xfer_count = xfer_count_q;
`else
    // Counter not built: no extra port, no extra state.
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_operand_stage
// Directed vector table, hand-written reset/perf sequences and a randomized
// phase checked against a queue model of a 2-deep FIFO with flush.
// ---------------------------------------------------------------------------
module tb_alu_operand_stage;

    localparam int N   = 32;
    localparam int OPW = 4;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_a;
    logic [N-1:0]   in_b;
    logic [OPW-1:0] in_op;
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_a;
    logic [N-1:0]   out_b;
    logic [OPW-1:0] out_op;
`ifdef ALU_OPSTAGE_PERF_EN
    logic [31:0]    xfer_count;
`endif

    alu_operand_stage #(.N(N), .OPW(OPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_op    (out_op)
`ifdef ALU_OPSTAGE_PERF_EN
        ,
        .xfer_count(xfer_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [OPW-1:0] op;
    } entry_t;

    // Reference model: the ordered list of entries the stage currently holds.
    entry_t model_q[$];

    typedef struct {
        logic           iv;
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [OPW-1:0] op;
        logic           ordy;
        logic           fl;
        logic           eov;
        logic           eir;
        logic [N-1:0]   ea;
        logic [N-1:0]   eb;
        logic [OPW-1:0] eop;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model across the edge, return #1 after it.
    task automatic step(input logic iv, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [OPW-1:0] op, input logic ordy, input logic fl);
        bit     m_accept;
        bit     m_send;
        entry_t e;
        in_valid  = iv;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        out_ready = ordy;
        flush     = fl;
        m_accept  = iv && (model_q.size() < 2);
        m_send    = ordy && (model_q.size() > 0);
        e.a = a; e.b = b; e.op = op;
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (m_send)   void'(model_q.pop_front());
            if (m_accept) model_q.push_back(e);
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, model_q.size() > 0});
        check({tag, ".in_ready"},  {31'd0, in_ready},  {31'd0, model_q.size() < 2});
        if (model_q.size() > 0) begin
            check({tag, ".out_a"},  out_a,           model_q[0].a);
            check({tag, ".out_b"},  out_b,           model_q[0].b);
            check({tag, ".out_op"}, {28'd0, out_op}, {28'd0, model_q[0].op});
        end
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        model_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    function automatic void add(input logic iv, input logic [N-1:0] a, input logic [N-1:0] b,
                                input logic [OPW-1:0] op, input logic ordy, input logic fl,
                                input logic eov, input logic eir, input logic [N-1:0] ea,
                                input logic [N-1:0] eb, input logic [OPW-1:0] eop);
        vec_t v;
        v.iv = iv; v.a = a; v.b = b; v.op = op; v.ordy = ordy; v.fl = fl;
        v.eov = eov; v.eir = eir; v.ea = ea; v.eb = eb; v.eop = eop;
        vecs.push_back(v);
    endfunction

    initial begin
        // -------------------- directed table --------------------
        // Single transfer, then drain to EMPTY.
        add(1, 32'h0000_00FF, 32'h0F0F_0F0F, 4'h3, 1, 0,  1, 1, 32'h0000_00FF, 32'h0F0F_0F0F, 4'h3);
        add(0, 32'h0,         32'h0,         4'h0, 1, 0,  0, 1, 32'h0, 32'h0, 4'h0);
        // Stream A=1..8 with out_ready high: one output per clock, in order.
        for (int k = 1; k <= 8; k++) begin
            add(1, k, k * 16, k[3:0], 1, 0,  1, 1, k, k * 16, k[3:0]);
        end
        add(0, 32'h0, 32'h0, 4'h0, 1, 0,  0, 1, 32'h0, 32'h0, 4'h0);
        // Backpressure: 10, 11 held (TWO), 12 waits upstream, then drain.
        add(1, 32'd10, 32'hA0, 4'hA, 0, 0,  1, 1, 32'd10, 32'hA0, 4'hA);
        add(1, 32'd11, 32'hB0, 4'hB, 0, 0,  1, 0, 32'd10, 32'hA0, 4'hA);
        add(1, 32'd12, 32'hC0, 4'hC, 0, 0,  1, 0, 32'd10, 32'hA0, 4'hA);
        add(1, 32'd12, 32'hC0, 4'hC, 1, 0,  1, 1, 32'd11, 32'hB0, 4'hB);
        add(1, 32'd12, 32'hC0, 4'hC, 1, 0,  1, 1, 32'd12, 32'hC0, 4'hC);
        add(0, 32'h0,  32'h0,  4'h0, 1, 0,  0, 1, 32'h0, 32'h0, 4'h0);
        // Flush from TWO: 20, 21 vanish.
        add(1, 32'd20, 32'h14, 4'h4, 0, 0,  1, 1, 32'd20, 32'h14, 4'h4);
        add(1, 32'd21, 32'h15, 4'h5, 0, 0,  1, 0, 32'd20, 32'h14, 4'h4);
        add(0, 32'h0,  32'h0,  4'h0, 0, 1,  0, 1, 32'h0, 32'h0, 4'h0);
        add(0, 32'h0,  32'h0,  4'h0, 1, 0,  0, 1, 32'h0, 32'h0, 4'h0);
        // Flush with a concurrent Accept in ONE: the new entry is dropped too.
        add(1, 32'd30, 32'h1E, 4'h6, 0, 0,  1, 1, 32'd30, 32'h1E, 4'h6);
        add(1, 32'd31, 32'h1F, 4'h7, 1, 1,  0, 1, 32'h0, 32'h0, 4'h0);
        add(0, 32'h0,  32'h0,  4'h0, 1, 0,  0, 1, 32'h0, 32'h0, 4'h0);

        // -------------------- reset values --------------------
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_op = '0;
        #3;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.in_ready",  {31'd0, in_ready},  32'd1);
        check("rst.out_a",     out_a,              32'd0);
        check("rst.out_b",     out_b,              32'd0);
        check("rst.out_op",    {28'd0, out_op},    32'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // -------------------- table loop --------------------
        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].ordy, vecs[i].fl);
            check($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].eov});
            check($sformatf("vec%0d.in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].eir});
            if (vecs[i].eov) begin
                check($sformatf("vec%0d.out_a", i),  out_a,           vecs[i].ea);
                check($sformatf("vec%0d.out_b", i),  out_b,           vecs[i].eb);
                check($sformatf("vec%0d.out_op", i), {28'd0, out_op}, {28'd0, vecs[i].eop});
            end
        end

        // -------------------- async reset mid-transfer --------------------
        step(1, 32'h55AA_55AA, 32'h1234_5678, 4'h9, 0, 0);
        step(1, 32'h0BAD_F00D, 32'h8765_4321, 4'h2, 0, 0);
        check("pre_arst.out_valid", {31'd0, out_valid}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("arst.out_valid", {31'd0, out_valid}, 32'd0);
        check("arst.in_ready",  {31'd0, in_ready},  32'd1);
        check("arst.out_a",     out_a,              32'd0);
        model_q.delete();
        #2;
        rst = 1'b0;

        // -------------------- randomized vs queue model --------------------
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(99, 0) < 65, $urandom, $urandom, 4'($urandom_range(15, 0)),
                 $urandom_range(99, 0) < 60, $urandom_range(31, 0) == 0);
            check_model($sformatf("rnd%0d", c));
        end

`ifdef ALU_OPSTAGE_PERF_EN
        // -------------------- transfer counter --------------------
        apply_reset();
        #1;
        check("perf.reset", xfer_count, 32'd0);
        for (int k = 0; k < 5; k++) begin
            step(1, k, k, 4'(k), 1, 0);
        end
        step(0, 32'h0, 32'h0, 4'h0, 1, 1);   // final Send concurrent with flush
        check("perf.five", xfer_count, 32'd5);
        force dut.xfer_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.xfer_count_q;
        step(1, 32'h77, 32'h88, 4'h1, 0, 0);
        check("perf.preload", xfer_count, 32'hFFFF_FFFF);
        step(0, 32'h0, 32'h0, 4'h0, 1, 0);
        check("perf.wrap", xfer_count, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
